// File: rtl/aes_key_sequencer.sv
// -----------------------------------------------------------------------------
// aes_key_sequencer
//   Drives the key_expansion strobe interface with timed level pulses, samples
//   the round key after a settle window and hands one round key per
//   valid/ready beat to the AES round datapath. Encrypt walks rounds 0..10,
//   decrypt walks 10..0. Decrypt needs the schedule walked once; if it has
//   not been walked, the block primes it with ten ready_enc pulses first.
//
// Parameters
//   PULSE_W  cycles each strobe is held high (and low between step pulses), >=1
//   SETTLE   cycles between a strobe falling and sampling key_expansion, >=1
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   key_load, key_data         load master key (accepted in IDLE only)
//   go, dec                    run a sequence; dec selects decrypt order
//   busy, done, err            status: not-IDLE, end-of-run pulse, go-without-key
//   ke_key_in                  master key to key_expansion
//   ke_set_new_key ..
//   ke_ready_dec               strobes to key_expansion (at most one high)
//   ke_key_enc, ke_key_dec     round keys from key_expansion
//   rk_valid, rk_ready         round-key handshake to the datapath
//   rk_data, rk_round, rk_last round key, its index, final-key flag
// -----------------------------------------------------------------------------
module aes_key_sequencer #(
  parameter int PULSE_W = 2,
  parameter int SETTLE  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] key_data,
  input  logic         go,
  input  logic         dec,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] ke_key_in,
  output logic         ke_set_new_key,
  output logic         ke_start_enc,
  output logic         ke_ready_enc,
  output logic         ke_start_dec,
  output logic         ke_ready_dec,
  input  logic [127:0] ke_key_enc,
  input  logic [127:0] ke_key_dec,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         rk_last
);

  localparam int MAXC = (PULSE_W > SETTLE) ? PULSE_W : SETTLE;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_PRIME_HI, S_PRIME_LO, S_START,
    S_SETTLE, S_PRESENT, S_STEP_HI, S_STEP_LO, S_DONE
  } state_t;

  state_t          r_state, w_nstate;
  logic [CW-1:0]   r_cnt;          // cycles spent in the current state
  logic [3:0]      r_prime;        // prime pulses completed
  logic            r_dec;          // mode of the current/pending run
  logic            r_pend_go;      // go arrived together with key_load
  logic            r_first;        // next sample is the first key of the run
  logic            r_key_loaded;
  logic            r_sched_valid;  // key_expansion has walked to round 10

  logic            w_pw_done, w_st_done, w_mode;
  logic            w_busy, w_done, w_err, w_set, w_senc, w_renc, w_sdec, w_rdec, w_valid;
  logic [3:0]      w_round_n;
  logic            w_last_n;

  assign w_pw_done = (r_cnt == CW'(PULSE_W - 1));
  assign w_st_done = (r_cnt == CW'(SETTLE - 1));

  // Round index and last flag for the key about to be presented.
  assign w_round_n = r_first ? (r_dec ? 4'd10 : 4'd0)
                             : (r_dec ? rk_round - 4'd1 : rk_round + 4'd1);
  assign w_last_n  = r_dec ? (w_round_n == 4'd0) : (w_round_n == 4'd10);

  // ---------------------------------------------------------------------------
  // State register, and the registered control outputs decoded from the next
  // state so every strobe is a clean flop output.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      ke_set_new_key <= 1'b0;
      ke_start_enc   <= 1'b0;
      ke_ready_enc   <= 1'b0;
      ke_start_dec   <= 1'b0;
      ke_ready_dec   <= 1'b0;
      rk_valid       <= 1'b0;
    end else begin
      r_state        <= w_nstate;
      r_cnt          <= (w_nstate != r_state) ? '0 : r_cnt + 1'b1;
      busy           <= w_busy;
      done           <= w_done;
      err            <= w_err;
      ke_set_new_key <= w_set;
      ke_start_enc   <= w_senc;
      ke_ready_enc   <= w_renc;
      ke_start_dec   <= w_sdec;
      ke_ready_dec   <= w_rdec;
      rk_valid       <= w_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE: begin
        if (key_load)
          w_nstate = S_LOAD;
        else if (go && r_key_loaded) begin
          // After a fresh load key_enc already shows round 0, so an encrypt
          // can skip the start pulse; decrypt must prime the schedule first.
          if (r_sched_valid) w_nstate = S_START;
          else               w_nstate = dec ? S_PRIME_HI : S_SETTLE;
        end
      end
      S_LOAD: begin
        // A load always leaves the schedule un-walked.
        if (w_pw_done)
          w_nstate = !r_pend_go ? S_IDLE : (r_dec ? S_PRIME_HI : S_SETTLE);
      end
      S_PRIME_HI: if (w_pw_done) w_nstate = S_PRIME_LO;
      S_PRIME_LO: if (w_pw_done) w_nstate = (r_prime == 4'd9) ? S_START : S_PRIME_HI;
      S_START:    if (w_pw_done) w_nstate = S_SETTLE;
      S_SETTLE:   if (w_st_done) w_nstate = S_PRESENT;
      S_PRESENT:  if (rk_valid && rk_ready) w_nstate = rk_last ? S_DONE : S_STEP_HI;
      S_STEP_HI:  if (w_pw_done) w_nstate = S_STEP_LO;
      S_STEP_LO:  if (w_pw_done) w_nstate = S_SETTLE;
      S_DONE:     w_nstate = S_IDLE;
      default:    w_nstate = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (values registered on the next edge)
  // ---------------------------------------------------------------------------
  always_comb begin
    // In IDLE the mode flop is being loaded from dec this very edge.
    w_mode  = (r_state == S_IDLE) ? dec : r_dec;
    w_busy  = (w_nstate != S_IDLE);
    w_done  = (w_nstate == S_DONE);
    w_err   = (r_state == S_IDLE) && go && !key_load && !r_key_loaded;
    w_set   = (w_nstate == S_LOAD);
    w_renc  = (w_nstate == S_PRIME_HI) || ((w_nstate == S_STEP_HI) && !w_mode);
    w_rdec  = (w_nstate == S_STEP_HI) && w_mode;
    w_senc  = (w_nstate == S_START) && !w_mode;
    w_sdec  = (w_nstate == S_START) && w_mode;
    w_valid = (w_nstate == S_PRESENT);
  end

  // ---------------------------------------------------------------------------
  // Key capture, schedule flags and round-key datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ke_key_in     <= '0;
      rk_data       <= '0;
      rk_round      <= '0;
      rk_last       <= 1'b0;
      r_prime       <= '0;
      r_dec         <= 1'b0;
      r_pend_go     <= 1'b0;
      r_first       <= 1'b0;
      r_key_loaded  <= 1'b0;
      r_sched_valid <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_dec   <= dec;
        r_first <= 1'b1;
        r_prime <= '0;
        if (key_load) begin
          ke_key_in     <= key_data;
          r_pend_go     <= go;
          r_key_loaded  <= 1'b1;
          r_sched_valid <= 1'b0;
        end
      end

      if (r_state == S_PRIME_LO && w_pw_done) begin
        r_prime <= r_prime + 4'd1;
        if (r_prime == 4'd9) r_sched_valid <= 1'b1;
      end

      // Sample only on the edge entering PRESENT; rk_* are frozen otherwise.
      if (r_state == S_SETTLE && w_st_done) begin
        rk_data  <= r_dec ? ke_key_dec : ke_key_enc;
        rk_round <= w_round_n;
        rk_last  <= w_last_n;
        r_first  <= 1'b0;
        if (!r_dec && w_round_n == 4'd10) r_sched_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sequencer.sv
module tb_aes_key_sequencer;
  localparam int PW = 2;
  localparam int ST = 2;
  localparam logic [127:0] JUNK = 128'hbadbadbadbadbadbadbadbadbadbadba;
  localparam logic [127:0] K0   = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk = 1'b0, rst_n = 1'b0;
  logic key_load = 1'b0, go = 1'b0, dec = 1'b0, rk_ready = 1'b1;
  logic [127:0] key_data = '0;
  logic busy, done, err, rk_valid, rk_last;
  logic ke_set_new_key, ke_start_enc, ke_ready_enc, ke_start_dec, ke_ready_dec;
  logic [127:0] ke_key_in, ke_key_enc, ke_key_dec, rk_data;
  logic [3:0] rk_round;

  aes_key_sequencer #(.PULSE_W(PW), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_data(key_data),
    .go(go), .dec(dec), .busy(busy), .done(done), .err(err),
    .ke_key_in(ke_key_in), .ke_set_new_key(ke_set_new_key),
    .ke_start_enc(ke_start_enc), .ke_ready_enc(ke_ready_enc),
    .ke_start_dec(ke_start_dec), .ke_ready_dec(ke_ready_dec),
    .ke_key_enc(ke_key_enc), .ke_key_dec(ke_key_dec),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_round(rk_round), .rk_last(rk_last));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- AES-128 key schedule (reference) ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [10:0][127:0] expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    logic [10:0][127:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return r;
  endfunction

  // ---------------- key_expansion peripheral model ----------------
  // Acts on strobe rising edges; its outputs read as junk until strobes have
  // been quiet for ST cycles, and key_dec is junk unless the schedule was walked.
  logic [10:0][127:0] ke_tbl = '0;
  int enc_r = 0, dec_r = 0, quiet = 100;
  bit primed = 0, dec_ok = 0;

  assign ke_key_enc = (quiet >= ST) ? ke_tbl[enc_r] : JUNK;
  assign ke_key_dec = (quiet >= ST && dec_ok) ? ke_tbl[dec_r] : JUNK;

  initial begin
    logic [4:0] s, ps, rise;
    ps = '0;
    forever begin
      @(negedge clk);
      s = {ke_set_new_key, ke_start_enc, ke_ready_enc, ke_start_dec, ke_ready_dec};
      rise = s & ~ps;
      if (rise[4]) begin ke_tbl = expand(ke_key_in); enc_r = 0; primed = 0; dec_ok = 0; end
      if (rise[3]) enc_r = 0;
      if (rise[2]) begin
        if (enc_r < 10) enc_r++;
        if (enc_r == 10) primed = 1;
      end
      if (rise[1]) begin dec_ok = primed; dec_r = 10; end
      if (rise[0] && dec_r > 0) dec_r--;
      quiet = (s != 0) ? 0 : ((quiet < 100) ? quiet + 1 : quiet);
      ps = s;
    end
  end

  // ---------------- shared expectation state ----------------
  int exp_q[$];
  logic [10:0][127:0] exp_tbl = '0;
  int first_at = -1, last_hs = -1, exp_err_at = -1, busy_from = -1, busy_to = -1;
  bit first_pend = 0, chk_en = 0, rand_rdy = 0;
  int n_str [5];
  bit m_loaded = 0, m_sv = 0;
  logic [127:0] m_key = '0;

  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    @(posedge clk); #2;
    rk_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- per-cycle compare process ----------------
  initial begin
    logic p_valid, p_last, hs, exp_done, exp_busy;
    logic [127:0] p_data;
    logic [3:0] p_round;
    logic [4:0] s, p_str;
    int runl [5];
    int r;
    p_valid = 0; p_last = 0; p_data = '0; p_round = '0; p_str = '0;
    for (int i = 0; i < 5; i++) runl[i] = 0;
    forever begin
      @(posedge clk); #1;
      s = {ke_set_new_key, ke_start_enc, ke_ready_enc, ke_start_dec, ke_ready_dec};
      if (!chk_en) begin
        p_valid = rk_valid; p_data = rk_data; p_round = rk_round; p_last = rk_last;
        p_str = '0;
        for (int i = 0; i < 5; i++) runl[i] = 0;
        continue;
      end
      chk("strobe_onehot", $countones(s) <= 1, 1);
      for (int i = 0; i < 5; i++) begin
        if (s[i]) runl[i]++;
        else if (p_str[i]) begin chk($sformatf("strobe%0d_width", i), runl[i], PW); runl[i] = 0; end
        if (s[i] && !p_str[i]) n_str[i]++;
      end
      hs = p_valid && rk_ready;
      if (p_valid && !rk_ready) chk("stall_valid", rk_valid, 1);
      if (hs) begin
        r = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk("beat_round", p_round, r);
        if (r >= 0) chk("beat_data", p_data, exp_tbl[r]);
        chk("beat_last", p_last, exp_q.size() == 0);
        last_hs = cyc;
      end
      exp_done = hs && p_last;
      chk("done", done, exp_done);
      if (exp_done) busy_to = cyc;
      if (rk_valid && !p_valid) begin
        if (first_pend) begin chk("first_latency", cyc, first_at); first_pend = 0; end
        else chk("step_latency", cyc - last_hs, 2*PW + ST);
      end else begin
        chk("hold_data", rk_data, p_data);
        chk("hold_round_last", {rk_round, rk_last}, {p_round, p_last});
      end
      exp_busy = (busy_from >= 0) && (cyc >= busy_from) && (busy_to < 0 || cyc <= busy_to);
      chk("busy", busy, exp_busy);
      chk("err", err, cyc == exp_err_at);
      p_valid = rk_valid; p_data = rk_data; p_round = rk_round; p_last = rk_last; p_str = s;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic clr_cnt();
    for (int i = 0; i < 5; i++) n_str[i] = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);   chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);     chk({tag, "_keyin"}, ke_key_in, 0);
    chk({tag, "_strobes"}, {ke_set_new_key, ke_start_enc, ke_ready_enc, ke_start_dec, ke_ready_dec}, 0);
    chk({tag, "_valid"}, rk_valid, 0); chk({tag, "_data"}, rk_data, 0);
    chk({tag, "_round"}, rk_round, 0); chk({tag, "_last"}, rk_last, 0);
  endtask

  task automatic try_err();
    clr_cnt();
    @(negedge clk); exp_err_at = cyc + 1; go = 1; dec = 1'($urandom);
    @(negedge clk); go = 0;
    repeat (3) @(negedge clk);
    chk("err_no_strobe", n_str[0] + n_str[1] + n_str[2] + n_str[3] + n_str[4], 0);
  endtask

  task automatic load_only(input logic [127:0] k);
    clr_cnt();
    @(negedge clk); busy_from = cyc + 1; busy_to = cyc + PW; key_load = 1; key_data = k; go = 0;
    @(negedge clk); key_load = 0;
    repeat (PW + 2) @(negedge clk);
    chk("load_set_pulses", n_str[4], 1);
    chk("load_key_in", ke_key_in, k);
    m_key = k; m_loaded = 1; m_sv = 0; busy_from = -1; busy_to = -1;
  endtask

  // Sets up expectations and issues go; returns sv at go time.
  task automatic start_run(input bit d, input bit ld, input logic [127:0] k, output bit sv0);
    int lat;
    if (ld) begin m_key = k; m_loaded = 1; m_sv = 0; end
    sv0 = m_sv;
    exp_tbl = expand(m_key);
    exp_q.delete();
    for (int i = 0; i < 11; i++) exp_q.push_back(d ? 10 - i : i);
    lat = (ld ? PW : 0) + (sv0 ? PW + ST : (d ? 21*PW + ST : ST));
    clr_cnt();
    @(negedge clk);
    first_at = cyc + 1 + lat; first_pend = 1; busy_from = cyc + 1; busy_to = -1;
    go = 1; dec = d; key_load = ld; key_data = k;
    @(negedge clk); go = 0; key_load = 0;
  endtask

  task automatic run(input bit d, input bit ld, input logic [127:0] k, input bit junk_go);
    bit sv0;
    start_run(d, ld, k, sv0);
    for (int i = 0; i < 3000 && busy_to < 0; i++) begin
      @(negedge clk);
      if (junk_go && i == 30) begin go = 1; key_load = 1; key_data = ~k; dec = ~d; end
      else begin go = 0; key_load = 0; end
    end
    go = 0; key_load = 0;
    chk("run_finished", busy_to >= 0, 1);
    chk("beats_left", exp_q.size(), 0);
    chk("first_seen", first_pend, 0);
    @(negedge clk);
    chk("n_set_new_key", n_str[4], ld);
    chk("n_start_enc", n_str[3], !d && sv0);
    chk("n_ready_enc", n_str[2], d ? (sv0 ? 0 : 10) : 10);
    chk("n_start_dec", n_str[1], d);
    chk("n_ready_dec", n_str[0], d ? 10 : 0);
    chk("run_key_in", ke_key_in, m_key);
    m_sv = 1; busy_from = -1; busy_to = -1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [10:0][127:0] t;
    logic [127:0] rk;
    logic [7:0] inv, b;
    bit sv0, ok;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      b = inv;
      sbox[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    end
    // Pin the reference model to published values.
    t = expand(K0);
    chk("model_round0", t[0], K0);
    chk("model_round1", t[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    chk("model_round10", t[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk); rst_n = 1; chk_en = 1;
    repeat (2) @(negedge clk);

    try_err();                       // go with no key
    load_only(K0);
    run(0, 0, K0, 0);                // enc, fresh schedule, no start pulse
    load_only(K0);
    run(1, 0, K0, 0);                // dec right after load: primes
    rand_rdy = 1;
    run(0, 0, K0, 1);                // enc with start_enc, stalls, go while busy
    run(1, 0, K0, 1);                // dec, schedule already walked
    rk = {$urandom, $urandom, $urandom, $urandom};
    run(0, 1, rk, 1);                // key_load + go same cycle
    for (int i = 0; i < 5; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      run(1'($urandom), 1'($urandom), rk, 1'($urandom));
    end

    // Reset in the middle of a decrypt run.
    rand_rdy = 0;
    rk = {$urandom, $urandom, $urandom, $urandom};
    load_only(rk);
    start_run(1, 0, rk, sv0);
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = (exp_q.size() == 6) && rk_valid;
    end
    chk("reached_round5", ok, 1);
    chk("round5_index", rk_round, 5);
    chk_en = 0;
    @(posedge clk); #3 rst_n = 0;
    #1 chk_zero("midreset");
    exp_q.delete(); first_pend = 0; busy_from = -1; busy_to = -1;
    m_loaded = 0; m_sv = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk); chk_en = 1;
    try_err();
    try_err();
    run(0, 1, rk, 0);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
